seq_subtractor_64bit: RTL
=========================

# seq_subtractor_64bit

Multi-cycle 64-bit subtractor that computes a − b − borrowIn one chunk per clock. It starts on a one-cycle start strobe and signals completion with a one-cycle done pulse. It is the counterpart of the combinational 64-bit ripple-carry adder in the arithmetic datapath. Area-constrained paths use it in place of a full-width combinational subtract, accepting a fixed latency of 64/CHUNK_WIDTH cycles.

## Interface
- CHUNK_WIDTH, 8, bits processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
- N (localparam), 64/CHUNK_WIDTH, number of processing cycles.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- a  input  64  minuend, unsigned or two's complement.
- b  input  64  subtrahend.
- borrowIn  input  1  incoming borrow.
- diff  output  64  result a − b − borrowIn mod 2^64.
- borrowOut  output  1  1 when unsigned a < b + borrowIn.
- overflow  output  1  signed overflow of the subtraction.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN on an edge with start=1:
  - latch a, b and borrowIn into internal registers;
  - set the chunk counter to 0;
  - set the internal carry to ~borrowIn.
- RUN, each edge:
  - chunk k = bits [k·CW+CW−1 : k·CW] are computed as a_k + ~b_k + carry;
  - the chunk result is stored in the diff shadow register;
  - carry becomes the chunk carry-out;
  - k increments.
- RUN → DONE on the edge that processes chunk N−1. On that same edge:
  - diff is loaded from the shadow register;
  - borrowOut = ~final carry;
  - overflow = (a[63] ≠ b[63]) & (diff[63] ≠ a[63]), using the latched operands.
- DONE → IDLE unconditionally on the next edge.
- diff, borrowOut and overflow hold their values until the end of the next operation. They do not change while a new operation is running.
- start is ignored in RUN and DONE, so there is no queuing. The a, b and borrowIn inputs are don't-care except on the accepting edge.
- Width rules:
  - all arithmetic is modulo 2^64;
  - the carry chain between chunks is one bit;
  - borrowOut is the inverse of the carry out of bit 63.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, counter = 0;
  - diff = 0, borrowOut = 0, overflow = 0, busy = 0, done = 0.
- Reset during RUN or DONE aborts the operation: no done pulse is produced and results return to 0. The first edge after rst deasserts may accept start.
- Latency: start is accepted at edge E0, results update at edge EN, and done is high for exactly the cycle between EN and EN+1.
  - CHUNK_WIDTH = 8: done rises 8 cycles after the accepting edge.
  - CHUNK_WIDTH = 1: done rises 64 cycles after the accepting edge.
- busy rises at E0 and falls at EN+1, so it is high for N+1 cycles.
- Throughput: at most one operation per N+2 cycles.
- Back-to-back operation: start held high continuously is accepted again at EN+2, the first edge in IDLE.

## Test plan
- a=95000000000000, b=39000000000000, borrowIn=0 → diff=56000000000000, borrowOut=0, overflow=0. done must be seen exactly one cycle, 8 cycles after the accepting edge.
- a=0, b=1, borrowIn=0 → diff=0xFFFFFFFFFFFFFFFF, borrowOut=1, overflow=0.
- Borrow-in and boundary cases:
  - a=1, b=0, borrowIn=1 → diff=0, borrowOut=0.
  - a=0, b=0, borrowIn=1 → diff=0xFFFFFFFFFFFFFFFF, borrowOut=1.
- a=0x8000000000000000, b=1 → diff=0x7FFFFFFFFFFFFFFF, overflow=1, borrowOut=0. Then a=4294967297, b=3 → diff=4294967294, with overflow and borrowOut both 0.
- Assert rst 3 cycles into RUN → outputs 0 immediately and no done pulse. After release, a=20000, b=30000 → diff=2^64−10000, borrowOut=1.
- Pulse start again mid-RUN with different operands → ignored; the first result stays correct and busy width is N+1. Repeat the first scenario with CHUNK_WIDTH=1 and CHUNK_WIDTH=64 → same results, with latency 64 and 1 respectively.

Source files
------------

// File: rtl/seq_subtractor_64bit_if.sv
// Request/result bundle for the multi-cycle 64-bit subtractor.
// The master drives operands and the start strobe; the slave returns results and status.
interface seq_subtractor_64bit_if;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        borrowIn;
  logic [63:0] diff;
  logic        borrowOut;
  logic        overflow;
  logic        busy;
  logic        done;

  modport master (
    output start, a, b, borrowIn,
    input  diff, borrowOut, overflow, busy, done
  );

  modport slave (
    input  start, a, b, borrowIn,
    output diff, borrowOut, overflow, busy, done
  );
endinterface

// File: rtl/seq_subtractor_64bit.sv
// Multi-cycle a - b - borrowIn, CHUNK_WIDTH bits per clock, computed as a + ~b + ~borrowIn.
// Results are held in output registers and only replaced when an operation completes.
module seq_sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_k,
  input  logic [W-1:0] b_k,
  input  logic         cin,
  output logic [W-1:0] res,
  output logic         cout
);
  always_comb begin
    {cout, res} = {1'b0, a_k} + {1'b0, ~b_k} + {{W{1'b0}}, cin};
  end
endmodule

module seq_subtractor_64bit #(
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_subtractor_64bit_if.slave bus
);
  localparam int CW    = CHUNK_WIDTH;
  localparam int N     = 64 / CW;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        a_sh_q, a_sh_d;
  logic [63:0]        b_sh_q, b_sh_d;
  logic [63:0]        shadow_q, shadow_d;
  logic               carry_q, carry_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [63:0]        diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;

  logic [CW-1:0]      ch_res;
  logic               ch_cout;
  logic               last_chunk;

  // Operands shift right one chunk per cycle so the active chunk is always the low CW bits.
  seq_sub_chunk #(.W(CW)) u_chunk (
    .a_k  (a_sh_q[CW-1:0]),
    .b_k  (b_sh_q[CW-1:0]),
    .cin  (carry_q),
    .res  (ch_res),
    .cout (ch_cout)
  );

  assign last_chunk = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    shadow_d = shadow_q;
    carry_d  = carry_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          cnt_d    = '0;
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          carry_d  = ~bus.borrowIn;
          sign_a_d = bus.a[63];
          sign_b_d = bus.b[63];
          shadow_d = '0;
        end
      end
      RUN: begin
        // Chunk results enter at the top; after N shifts chunk 0 sits at bit 0.
        shadow_d = (shadow_q >> CW) | (64'(ch_res) << (64 - CW));
        a_sh_d   = a_sh_q >> CW;
        b_sh_d   = b_sh_q >> CW;
        carry_d  = ch_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_chunk) begin
          state_d  = DONE;
          cnt_d    = '0;
          diff_d   = shadow_d;
          borrow_d = ~ch_cout;
          ovf_d    = (sign_a_q ^ sign_b_q) & (shadow_d[63] ^ sign_a_q);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      shadow_q <= '0;
      carry_q  <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      shadow_q <= shadow_d;
      carry_q  <= carry_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.diff      = diff_q;
  assign bus.borrowOut = borrow_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
endmodule
